// File: rtl/aes_inv_128_if.sv
// Handshake bundle for the iterative AES-128 decryptor: ciphertext/key in, plaintext out.
// The master side offers blocks and consumes plaintext; the slave side is the decryptor.
interface aes_inv_128_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_128.sv
// Iterative AES-128 decryptor: forward key expansion to round key 10, then one inverse round
// per cycle while walking the key schedule backward. Round key 10 is cached per key.
module sbox_c (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] y;
    logic [7:0] p;
    y = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) y = gf_mul(y, p);
      p = gf_mul(p, p);
    end
    return y;
  endfunction

  logic [7:0] b;
  always_comb begin
    b   = gf_inv(a_i);
    y_o = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end
endmodule

module inv_sbox_c (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] y;
    logic [7:0] p;
    y = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) y = gf_mul(y, p);
      p = gf_mul(p, p);
    end
    return y;
  endfunction

  logic [7:0] b;
  always_comb begin
    // Undo the affine map first, then invert in GF(2^8).
    b   = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
    y_o = gf_inv(b);
  end
endmodule

module aes_inv_128 (
  input logic          clk,
  input logic          rst_n,
  aes_inv_128_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StExpand, StRound, StDone} state_e;

  state_e       state_q, state_d;
  logic [127:0] ct_q, ct_d, key_q, key_d, rk_q, rk_d, st_q, st_d;
  logic [127:0] cache_key_q, cache_key_d, cache_rk10_q, cache_rk10_d;
  logic [127:0] out_data_q, out_data_d;
  logic         cache_vld_q, cache_vld_d;
  logic [3:0]   cnt_q, cnt_d;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    logic [7:0]   x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127-8*(4*c+r) -: 8];
        x2    = xtime(a[r]);
        x4    = xtime(x2);
        x8    = xtime(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      o[127-32*c -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[119-32*c -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[111-32*c -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[103-32*c -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

  // Key schedule: the four forward S-boxes serve both the forward and the backward step.
  logic [31:0]  w0, w1, w2, w3, b1, b2, b3;
  logic [31:0]  sub_in, rot_w, sub_w, temp_w, f0, f1, f2, f3;
  logic [3:0]   rc_idx;
  logic [127:0] rk_fwd, rk_bwd;

  always_comb begin
    {w0, w1, w2, w3} = rk_q;
    b3     = w3 ^ w2;
    b2     = w2 ^ w1;
    b1     = w1 ^ w0;
    sub_in = (state_q == StRound) ? b3 : w3;
    rot_w  = {sub_in[23:0], sub_in[31:24]};
    rc_idx = (state_q == StRound) ? (4'd9 - cnt_q) : cnt_q;
    temp_w = sub_w ^ {rcon(rc_idx), 24'h000000};
    f0     = w0 ^ temp_w;
    f1     = w1 ^ f0;
    f2     = w2 ^ f1;
    f3     = w3 ^ f2;
    rk_fwd = {f0, f1, f2, f3};
    rk_bwd = {w0 ^ temp_w, b1, b2, b3};
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox_c u_sbox (
      .a_i(rot_w[31-8*g -: 8]),
      .y_o(sub_w[31-8*g -: 8])
    );
  end

  logic [127:0] isr, isb, ark, imc;

  assign isr = inv_shift_rows(st_q);

  for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
    inv_sbox_c u_inv_sbox (
      .a_i(isr[127-8*g -: 8]),
      .y_o(isb[127-8*g -: 8])
    );
  end

  assign ark = isb ^ rk_bwd;
  assign imc = inv_mix_columns(ark);

  always_comb begin
    state_d      = state_q;
    ct_d         = ct_q;
    key_d        = key_q;
    rk_d         = rk_q;
    st_d         = st_q;
    cnt_d        = cnt_q;
    cache_key_d  = cache_key_q;
    cache_rk10_d = cache_rk10_q;
    cache_vld_d  = cache_vld_q;
    out_data_d   = out_data_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          ct_d  = bus.in_data;
          key_d = bus.in_key;
          cnt_d = 4'd0;
          if (cache_vld_q && (bus.in_key == cache_key_q)) begin
            rk_d    = cache_rk10_q;
            st_d    = bus.in_data ^ cache_rk10_q;
            state_d = StRound;
          end else begin
            rk_d    = bus.in_key;
            state_d = StExpand;
          end
        end
      end
      StExpand: begin
        rk_d = rk_fwd;
        if (cnt_q == 4'd9) begin
          st_d         = ct_q ^ rk_fwd;
          cache_key_d  = key_q;
          cache_rk10_d = rk_fwd;
          cache_vld_d  = 1'b1;
          cnt_d        = 4'd0;
          state_d      = StRound;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRound: begin
        rk_d = rk_bwd;
        if (cnt_q == 4'd9) begin
          // Final round has no InvMixColumns.
          out_data_d = ark;
          state_d    = StDone;
        end else begin
          st_d  = imc;
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ct_q         <= '0;
      key_q        <= '0;
      rk_q         <= '0;
      st_q         <= '0;
      cnt_q        <= '0;
      cache_key_q  <= '0;
      cache_rk10_q <= '0;
      cache_vld_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      ct_q         <= ct_d;
      key_q        <= key_d;
      rk_q         <= rk_d;
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      cache_key_q  <= cache_key_d;
      cache_rk10_q <= cache_rk10_d;
      cache_vld_q  <= cache_vld_d;
      out_data_q   <= out_data_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_aes_inv_128.sv
// Bench for aes_inv_128: textbook AES-128 model (full key schedule, round-by-round cipher),
// a cache/latency model of the block, and one negedge monitor checking every output.
module tb_aes_inv_128;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  aes_inv_128_if bus ();

  aes_inv_128 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_out = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc;
  } exp_t;
  exp_t q[$];
  logic [127:0] c_key = '0;
  logic         c_vld = 1'b0;
  logic [127:0] held = '0;
  logic [127:0] last_out = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] v, input int k);
    return v[127-8*k -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] rkey(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv ? isb[gb(v, k)] : sb[gb(v, k)];
    return o;
  endfunction

  // dir=+1: ShiftRows (row r rotates left by r); dir=-1: InvShiftRows.
  function automatic logic [127:0] shift(input logic [127:0] v, input int dir);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gb(v, 4*((c + 4 + dir*r) % 4) + r);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] v, input bit inv);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   acc;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(m[(j - r + 4) % 4], gb(v, 4*c+j));
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s = pt ^ rkey(key, 0);
    for (int r = 1; r <= 10; r++) begin
      s = shift(sub_bytes(s, 1'b0), 1);
      if (r < 10) s = mix(s, 1'b0);
      s = s ^ rkey(key, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [127:0] key);
    logic [127:0] s = ct ^ rkey(key, 10);
    for (int r = 9; r >= 0; r--) begin
      s = sub_bytes(shift(s, -1), 1'b1) ^ rkey(key, r);
      if (r > 0) s = mix(s, 1'b1);
    end
    return s;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    logic ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        c_vld   = 1'b0;
        ov_prev = 1'b0;
      end else begin
        cyc++;
        if (bus.in_valid && bus.in_ready) begin
          e.pt  = model_dec(bus.in_data, bus.in_key);
          e.lat = (c_vld && bus.in_key == c_key) ? 10 : 20;
          e.acc = cyc;
          q.push_back(e);
          c_key = bus.in_key;
          c_vld = 1'b1;
        end
        if (bus.out_valid && !ov_prev) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: out_valid=1 data %h, want no output", bus.out_data);
          end else begin
            e = q.pop_front();
            chk("plaintext", bus.out_data, e.pt);
            chk("latency", 128'(cyc - e.acc - 1), 128'(e.lat));
          end
          held     = bus.out_data;
          last_out = bus.out_data;
          n_out++;
        end else if (bus.out_valid) begin
          chk("out_hold", bus.out_data, held);
        end
        if (bus.out_valid) chk("in_ready_in_done", 128'(bus.in_ready), 128'(0));
        ov_prev = bus.out_valid;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want summary first");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [127:0] ct, input logic [127:0] key, output int acc);
    acc = -1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    bus.in_key   = key;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        acc = cyc;
        #1 bus.in_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send_timeout: in_ready=%0b after 80 cycles, want 1", bus.in_ready);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.out_valid && bus.in_ready) return;
    end
    total++;
    bad++;
    $display("FAIL idle_timeout: pending=%0d out_valid=%0b, want 0 and 0", q.size(), bus.out_valid);
  endtask

  task automatic wait_out();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.out_valid) return;
    end
    total++;
    bad++;
    $display("FAIL out_timeout: out_valid=%0b after 60 cycles, want 1", bus.out_valid);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [7:0]   p, qq, x;
    logic [127:0] kpool [3];
    logic [127:0] pt, ct, k;
    int           a1, a2, snap;

    p  = 8'h01;
    qq = 8'h01;
    do begin
      p  = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      qq = qq ^ {qq[6:0], 1'b0};
      qq = qq ^ {qq[5:0], 2'b00};
      qq = qq ^ {qq[3:0], 4'h0};
      if (qq[7]) qq = qq ^ 8'h09;
      x = qq ^ {qq[6:0], qq[7]} ^ {qq[5:0], qq[7:6]} ^ {qq[4:0], qq[7:5]} ^ {qq[3:0], qq[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = i[7:0];

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b1;

    chk("model_sbox53", 128'(sb[8'h53]), 128'h ed);
    chk("model_isbox00", 128'(isb[8'h00]), 128'h52);
    chk("model_rk10", rkey(B_KEY, 10), B_RK10);
    chk("model_dec_b", model_dec(B_CT, B_KEY), B_PT);
    chk("model_enc_c", model_enc(C_PT, C_KEY), C_CT);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", bus.out_data, 128'h0);

    send(B_CT, B_KEY, a1); wait_idle(); chk("appb_miss", last_out, B_PT);
    send(B_CT, B_KEY, a1); wait_idle(); chk("appb_hit", last_out, B_PT);
    send(C_CT, C_KEY, a1); wait_idle(); chk("c1_miss", last_out, C_PT);
    send(C_CT, C_KEY, a1); wait_idle(); chk("c1_hit", last_out, C_PT);

    send(C_CT, C_KEY, a1);
    send(C_CT, C_KEY, a2);
    chk("thru_hit", 128'(a2 - a1), 128'(12));
    wait_idle();
    send(B_CT, B_KEY, a1);
    send(B_CT, B_KEY, a2);
    chk("thru_miss", 128'(a2 - a1), 128'(22));
    wait_idle();

    // Backpressure: DONE held while a new block is offered.
    bus.out_ready = 1'b0;
    send(C_CT, C_KEY, a1);
    wait_out();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = B_CT;
    bus.in_key   = B_KEY;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
      chk("bp_data", bus.out_data, C_PT);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_in_ready", 128'(bus.in_ready), 128'(0));
    @(negedge clk);
    chk("bp_after_in_ready", 128'(bus.in_ready), 128'(1));
    chk("bp_after_out_valid", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_idle();
    chk("bp_second_block", last_out, B_PT);

    // Random blocks from a small key pool so both hits and misses occur.
    for (int i = 0; i < 3; i++) kpool[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = kpool[$urandom_range(0, 2)];
      ct = model_enc(pt, k);
      bus.out_ready = 1'b0;
      send(ct, k, a1);
      wait_out();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      wait_idle();
      chk("rand_roundtrip", last_out, pt);
    end

    // Reset in ROUND cnt=4 of a miss; cache must be invalidated.
    send(C_CT, C_KEY, a1);
    wait_idle();
    snap = n_out;
    send(B_CT, B_KEY, a1);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_no_output", 128'(n_out), 128'(snap));
    send(B_CT, B_KEY, a1);
    wait_idle();
    chk("post_rst_appb", last_out, B_PT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
